// File: rtl/txrx_slot_sched.sv
// Slot-level TX/RX scheduler: picks TX or RX for each 625 us slot, sequences the
// packet datapath and reports start/done/receive/timeout events as one-cycle pulses.
module txrx_slot_sched (
  input  logic       clk_6M,
  input  logic       rst,
  input  logic       enable,
  input  logic       is_master,
  input  logic       p_1us,
  input  logic       slot_st_p,
  input  logic       CLK1,
  input  logic       tx_req,
  input  logic [2:0] tx_occ_slots,
  input  logic       txbit_period,
  input  logic       rx_sync_p,
  input  logic       rx_done_p,
  input  logic [9:0] regi_rxwin_us,
  output logic       pk_encode,
  output logic       tx_packet_st_p,
  output logic       tx_ack_p,
  output logic       tx_done_p,
  output logic       rx_window,
  output logic       rx_ok_p,
  output logic       rx_timeout_p,
  output logic [2:0] sched_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX      = 3'd1,
    S_TX_WAIT = 3'd2,
    S_RX_WIN  = 3'd3,
    S_RX_PKT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] slot_cnt_q, slot_cnt_d;
  logic [2:0] occ_q, occ_d;
  logic [9:0] us_cnt_q, us_cnt_d;
  logic       txbit_q;
  logic       tx_packet_st_d, tx_ack_d, tx_done_d, rx_ok_d, rx_timeout_d;
  logic       tx_packet_st_q, tx_ack_q, tx_done_q, rx_ok_q, rx_timeout_q;

  logic        own_tx_slot;
  logic        txbit_fall;
  logic [2:0]  slot_inc;
  logic [10:0] us_next;
  state_t      tx_dest;

  // tx_req is a level request; tx_ack_p is the single-cycle acceptance, after which
  // the link controller may drop or change tx_req and tx_occ_slots.
  always_comb begin
    own_tx_slot = is_master ? ~CLK1 : CLK1;
    txbit_fall  = txbit_q & ~txbit_period;
    slot_inc    = (slot_cnt_q == 3'd7) ? 3'd7 : slot_cnt_q + 3'd1;
    us_next     = {1'b0, us_cnt_q} + {10'd0, p_1us};
    tx_dest     = is_master ? S_RX_WIN : S_IDLE;

    state_d        = state_q;
    slot_cnt_d     = slot_cnt_q;
    occ_d          = occ_q;
    us_cnt_d       = 10'd0;
    tx_packet_st_d = 1'b0;
    tx_ack_d       = 1'b0;
    tx_done_d      = 1'b0;
    rx_ok_d        = 1'b0;
    rx_timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        slot_cnt_d = 3'd0;
        if (slot_st_p) begin
          if (own_tx_slot && tx_req) begin
            state_d        = S_TX;
            tx_packet_st_d = 1'b1;
            tx_ack_d       = 1'b1;
            occ_d          = (tx_occ_slots == 3'd1 || tx_occ_slots == 3'd3 ||
                              tx_occ_slots == 3'd5) ? tx_occ_slots : 3'd1;
          end else if (!is_master && !CLK1) begin
            state_d = S_RX_WIN;
          end
        end
      end
      S_TX: begin
        if (slot_st_p) slot_cnt_d = slot_inc;
        // Datapath overran its slot budget: close the packet ourselves.
        if (slot_st_p && slot_inc == occ_q + 3'd1) begin
          tx_done_d = 1'b1;
          state_d   = tx_dest;
        end else if (txbit_fall) begin
          tx_done_d = 1'b1;
          state_d   = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (slot_st_p) begin
          slot_cnt_d = slot_inc;
          if (slot_inc >= occ_q) state_d = tx_dest;
        end
      end
      S_RX_WIN: begin
        slot_cnt_d = 3'd0;
        us_cnt_d   = us_next[9:0];
        if (rx_sync_p) begin
          state_d = S_RX_PKT;
        end else if (us_next >= {1'b0, regi_rxwin_us}) begin
          rx_timeout_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_RX_PKT: begin
        if (slot_st_p) slot_cnt_d = slot_inc;
        if (rx_done_p) begin
          rx_ok_d = 1'b1;
          state_d = S_IDLE;
        end else if (slot_st_p && slot_inc == 3'd6) begin
          rx_timeout_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d        = S_IDLE;
      slot_cnt_d     = 3'd0;
      us_cnt_d       = 10'd0;
      tx_packet_st_d = 1'b0;
      tx_ack_d       = 1'b0;
      tx_done_d      = 1'b0;
      rx_ok_d        = 1'b0;
      rx_timeout_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q        <= S_IDLE;
      slot_cnt_q     <= 3'd0;
      occ_q          <= 3'd0;
      us_cnt_q       <= 10'd0;
      txbit_q        <= 1'b0;
      tx_packet_st_q <= 1'b0;
      tx_ack_q       <= 1'b0;
      tx_done_q      <= 1'b0;
      rx_ok_q        <= 1'b0;
      rx_timeout_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_cnt_q     <= slot_cnt_d;
      occ_q          <= occ_d;
      us_cnt_q       <= us_cnt_d;
      txbit_q        <= txbit_period;
      tx_packet_st_q <= tx_packet_st_d;
      tx_ack_q       <= tx_ack_d;
      tx_done_q      <= tx_done_d;
      rx_ok_q        <= rx_ok_d;
      rx_timeout_q   <= rx_timeout_d;
    end
  end

  assign pk_encode      = (state_q == S_TX) || (state_q == S_TX_WAIT);
  assign rx_window      = (state_q == S_RX_WIN);
  assign tx_packet_st_p = tx_packet_st_q;
  assign tx_ack_p       = tx_ack_q;
  assign tx_done_p      = tx_done_q;
  assign rx_ok_p        = rx_ok_q;
  assign rx_timeout_p   = rx_timeout_q;
  assign sched_state    = state_q;

endmodule

// File: tb/tb_txrx_slot_sched.sv
// Directed bench for txrx_slot_sched: hand-computed state/output vectors per scenario.
module tb_txrx_slot_sched;

  logic       clk_6M = 1'b0;
  logic       rst = 1'b0, enable = 1'b0, is_master = 1'b0, p_1us = 1'b0;
  logic       slot_st_p = 1'b0, CLK1 = 1'b0, tx_req = 1'b0, txbit_period = 1'b0;
  logic       rx_sync_p = 1'b0, rx_done_p = 1'b0;
  logic [2:0] tx_occ_slots = 3'd0;
  logic [9:0] regi_rxwin_us = 10'd0;
  logic       pk_encode, tx_packet_st_p, tx_ack_p, tx_done_p;
  logic       rx_window, rx_ok_p, rx_timeout_p;
  logic [2:0] sched_state;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_PK   = 7'b1000000;
  localparam logic [6:0] F_WIN  = 7'b0100000;
  localparam logic [6:0] F_PST  = 7'b0010000;
  localparam logic [6:0] F_ACK  = 7'b0001000;
  localparam logic [6:0] F_DONE = 7'b0000100;
  localparam logic [6:0] F_OK   = 7'b0000010;
  localparam logic [6:0] F_TO   = 7'b0000001;

  txrx_slot_sched dut (
    .clk_6M(clk_6M), .rst(rst), .enable(enable), .is_master(is_master),
    .p_1us(p_1us), .slot_st_p(slot_st_p), .CLK1(CLK1), .tx_req(tx_req),
    .tx_occ_slots(tx_occ_slots), .txbit_period(txbit_period),
    .rx_sync_p(rx_sync_p), .rx_done_p(rx_done_p), .regi_rxwin_us(regi_rxwin_us),
    .pk_encode(pk_encode), .tx_packet_st_p(tx_packet_st_p), .tx_ack_p(tx_ack_p),
    .tx_done_p(tx_done_p), .rx_window(rx_window), .rx_ok_p(rx_ok_p),
    .rx_timeout_p(rx_timeout_p), .sched_state(sched_state)
  );

  always #83 clk_6M = ~clk_6M;

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic slot(input logic clk1);
    slot_st_p = 1'b1;
    CLK1      = clk1;
    step();
    slot_st_p = 1'b0;
  endtask

  task automatic tick();
    p_1us = 1'b1;
    step();
    p_1us = 1'b0;
    step();
  endtask

  task automatic tx_fall();
    txbit_period = 1'b1;
    idle(2);
    txbit_period = 1'b0;
    step();
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // flags: {pk_encode, rx_window, tx_packet_st_p, tx_ack_p, tx_done_p, rx_ok_p, rx_timeout_p}
  task automatic check_out(input string tag, input logic [2:0] st, input logic [6:0] fl);
    check_val(tag, {6'd0, sched_state, pk_encode, rx_window, tx_packet_st_p, tx_ack_p,
                    tx_done_p, rx_ok_p, rx_timeout_p}, {6'd0, st, fl});
  endtask

  initial begin
    rst = 1'b1;
    step();
    check_out("reset", 3'd0, F_NONE);
    rst = 1'b0;
    enable = 1'b1;
    is_master = 1'b1;
    regi_rxwin_us = 10'd20;
    idle(2);
    check_out("idle_after_reset", 3'd0, F_NONE);

    // Master single-slot packet
    tx_req = 1'b1; tx_occ_slots = 3'd1;
    slot(1'b0);
    check_out("m_tx_start", 3'd1, F_PK | F_PST | F_ACK);
    tx_req = 1'b0;
    step();
    check_out("m_tx_hold", 3'd1, F_PK);
    tx_fall();
    check_out("m_tx_done", 3'd2, F_PK | F_DONE);
    step();
    check_out("m_tx_wait", 3'd2, F_PK);
    slot(1'b1);
    check_out("m_rx_win", 3'd3, F_WIN);

    // 20 us window, no sync
    for (int i = 0; i < 19; i++) tick();
    check_out("win_19us", 3'd3, F_WIN);
    p_1us = 1'b1;
    step();
    p_1us = 1'b0;
    check_out("win_timeout", 3'd0, F_TO);
    step();
    check_out("win_to_clear", 3'd0, F_NONE);

    // Slave RX: sync on the 20th tick wins, then packet received
    is_master = 1'b0;
    tx_req = 1'b1;
    slot(1'b0);
    check_out("s_rx_win", 3'd3, F_WIN);
    tx_req = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    p_1us = 1'b1; rx_sync_p = 1'b1;
    step();
    p_1us = 1'b0; rx_sync_p = 1'b0;
    check_out("sync_beats_to", 3'd4, F_NONE);
    idle(3);
    rx_done_p = 1'b1;
    step();
    rx_done_p = 1'b0;
    check_out("s_rx_ok", 3'd0, F_OK);

    // Slave 3-slot TX returns to IDLE
    tx_req = 1'b1; tx_occ_slots = 3'd3;
    slot(1'b1);
    check_out("s_tx_start", 3'd1, F_PK | F_PST | F_ACK);
    tx_req = 1'b0;
    tx_fall();
    check_out("s_tx_done", 3'd2, F_PK | F_DONE);
    slot(1'b0);
    slot(1'b1);
    check_out("s_tx_wait2", 3'd2, F_PK);
    slot(1'b0);
    check_out("s_tx_idle", 3'd0, F_NONE);

    // Zero-length window times out on its first cycle
    regi_rxwin_us = 10'd0;
    slot(1'b0);
    check_out("s_win0_enter", 3'd3, F_WIN);
    step();
    check_out("win0_timeout", 3'd0, F_TO);

    // Master 5-slot packet
    is_master = 1'b1;
    tx_req = 1'b1; tx_occ_slots = 3'd5;
    slot(1'b0);
    tx_req = 1'b0;
    check_out("m5_start", 3'd1, F_PK | F_PST | F_ACK);
    tx_fall();
    for (int i = 0; i < 4; i++) slot(1'b1);
    check_out("m5_wait4", 3'd2, F_PK);
    slot(1'b0);
    check_out("m5_rx_win", 3'd3, F_WIN);
    step();

    // occ=6 is treated as a single slot
    tx_req = 1'b1; tx_occ_slots = 3'd6;
    slot(1'b0);
    tx_req = 1'b0;
    tx_fall();
    slot(1'b1);
    check_out("m6_as_1", 3'd3, F_WIN);
    step();

    // Stuck datapath: forced done at occ+1
    tx_req = 1'b1; tx_occ_slots = 3'd1;
    slot(1'b0);
    tx_req = 1'b0;
    slot(1'b1);
    check_out("stuck_1slot", 3'd1, F_PK);
    slot(1'b0);
    check_out("stuck_forced", 3'd3, F_WIN | F_DONE);
    step();

    // Enable dropped mid-TX, and slots ignored while disabled
    tx_req = 1'b1;
    slot(1'b0);
    step();
    enable = 1'b0;
    step();
    check_out("en_drop", 3'd0, F_NONE);
    slot(1'b0);
    check_out("en_off_slot", 3'd0, F_NONE);
    enable = 1'b1;
    tx_req = 1'b0;
    step();

    // RX_PKT watchdog on the 6th slot
    is_master = 1'b0;
    regi_rxwin_us = 10'd20;
    slot(1'b0);
    rx_sync_p = 1'b1;
    step();
    rx_sync_p = 1'b0;
    for (int i = 0; i < 5; i++) slot(1'b1);
    check_out("wd_5slots", 3'd4, F_NONE);
    slot(1'b0);
    check_out("wd_timeout", 3'd0, F_TO);

    // Reset mid-RX_PKT aborts with no pulses
    slot(1'b0);
    rx_sync_p = 1'b1;
    step();
    rx_sync_p = 1'b0;
    check_out("pre_rst_pkt", 3'd4, F_NONE);
    rst = 1'b1;
    step();
    check_out("rst_mid_pkt", 3'd0, F_NONE);
    rst = 1'b0;
    step();
    check_out("post_rst", 3'd0, F_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
